jk_cmd_seq: RTL and testbench

- Upstream driver for the JK flip-flop stage.
- Accepts {op, length} commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command as registered j/k levels for a programmed number of clock cycles; j/k connect directly to the flip-flop's j/k inputs on the same clk/reset_n.

---
 rtl/jk_cmd_pkg.sv | 33 +++
 rtl/jk_cmd_fifo.sv | 59 +++++
 rtl/jk_cmd_seq.sv | 129 ++++++++++++
 tb/tb_jk_cmd_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_cmd_pkg.sv
// Shared types for the JK command sequencer: op encodings, FSM states and the command record.
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } jk_state_e;

  localparam int unsigned CMD_LEN_W = 4;

  typedef struct packed {
    jk_op_e               op;
    logic [CMD_LEN_W-1:0] len;
  } jk_cmd_t;

  // Next state of a JK flip-flop given its current j/k drive and output.
  function automatic logic jk_next_q(input jk_op_e op, input logic q);
    case (op)
      OP_HOLD:  return q;
      OP_RESET: return 1'b0;
      OP_SET:   return 1'b1;
      default:  return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous power-of-two FIFO; a push while full or a pop while empty is ignored.
module jk_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pushEn, popEn;

  // Full is checked on the current count only, so a same-edge pop never frees a slot for a push.
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushEn  = push_i && !full_o;
  assign popEn   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEn) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popEn)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (pushEn && !popEn)      count_d = count_q + (PTR_W+1)'(1);
    else if (popEn && !pushEn) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Replays queued {op, len} commands as registered j/k drive for a JK flip-flop stage.
// Defining JK_CMD_SEQ_CHECK_EN adds a flip-flop mirror that sets a sticky err on q_in mismatch.
module jk_cmd_seq
  import jk_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = CMD_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  input  logic             q_in,
  output logic             err
);

  typedef struct packed {
    jk_op_e           op;
    logic [CNT_W-1:0] len;
  } cmd_t;

  cmd_t                   inCmd, headCmd;
  logic                   fifoFull, fifoEmpty;
  logic                   pushEn, popEn, lastCycle;
  logic [$clog2(DEPTH):0] unusedFifoCount;

  jk_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             j_q, k_q, busy_q, done_q;

  assign inCmd.op  = jk_op_e'(cmd_op);
  assign inCmd.len = cmd_len;

  assign cmd_ready = reset_n && !fifoFull;
  assign pushEn    = cmd_valid && cmd_ready;
  assign lastCycle = (state_q == RUN) && (cnt_q == '0);
  assign popEn     = reset_n && !fifoEmpty && ((state_q == IDLE) || lastCycle);

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .push_i   (pushEn),
    .data_i   (inCmd),
    .pop_i    (popEn),
    .data_o   (headCmd),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty),
    .count_o  (unusedFifoCount)
  );

  // A finishing command hands straight over to the next queued one so j/k never gap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            {j_q, k_q} <= headCmd.op;
            cnt_q      <= headCmd.len;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else begin
            j_q <= 1'b0;
            k_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            done_q <= 1'b1;
            if (!fifoEmpty) begin
              {j_q, k_q} <= headCmd.op;
              cnt_q      <= headCmd.len;
            end else begin
              j_q     <= 1'b0;
              k_q     <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef JK_CMD_SEQ_CHECK_EN
  logic expQ_q, err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      expQ_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      expQ_q <= jk_next_q(jk_op_e'({j_q, k_q}), expQ_q);
      if (q_in != expQ_q) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unusedQIn;
  assign unusedQIn = q_in;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed vector table, multi-cycle corner sequences and a randomized
// run, all compared against a queue-based model of the command stream.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             cmd_ready, j, k, busy, done, q_in, err;
  logic             ffY = 1'b0;
  logic             injectQ = 1'b0;

  int errCount = 0;
  int checkCount = 0;
  int doneSeen;

  jk_cmd_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_in      (q_in),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Downstream JK flip-flop fed by the DUT; q_in can be corrupted on demand.
  always @(posedge clk) begin
    if (!reset_n) ffY <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ffY <= 1'b0;
        2'b10:   ffY <= 1'b1;
        2'b11:   ffY <= ~ffY;
        default: ffY <= ffY;
      endcase
    end
  end
  assign q_in = ffY ^ injectQ;

  // Reference model: pending command queue plus "apply cycles left" for the active command.
  typedef struct {
    logic [1:0] op;
    int         len;
  } mcmd_t;

  mcmd_t      pend[$];
  logic [1:0] curOp = 2'b00;
  int         left = 0;
  logic       expDone = 1'b0;
  logic       errExp = 1'b0;

  task automatic modelEdge();
    logic  canPush;
    mcmd_t c;
    if (!reset_n) begin
      pend.delete();
      left    = 0;
      curOp   = 2'b00;
      expDone = 1'b0;
      errExp  = 1'b0;
    end else begin
      canPush = (pend.size() < DEPTH);
`ifdef JK_CMD_SEQ_CHECK_EN
      if (injectQ) errExp = 1'b1;
`endif
      expDone = (left == 1);
      if (left > 1) left--;
      else if (pend.size() > 0) begin
        c     = pend.pop_front();
        curOp = c.op;
        left  = c.len + 1;
      end else begin
        left  = 0;
        curOp = 2'b00;
      end
      if (cmd_valid && canPush) begin
        c.op  = cmd_op;
        c.len = int'(cmd_len);
        pend.push_back(c);
      end
    end
  endtask

  function automatic logic [5:0] modelVec();
    logic act;
    logic rdy;
    act = (left > 0);
    rdy = reset_n && (pend.size() < DEPTH);
    return {act & curOp[1], act & curOp[0], act, expDone, rdy, errExp};
  endfunction

  task automatic applyStimulus(input logic rstN, input logic v, input logic [1:0] op,
                               input logic [CNT_W-1:0] len);
    reset_n   = rstN;
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expV);
    logic [5:0] act;
    act = {j, k, busy, done, cmd_ready, err};
    checkCount++;
    if (act !== expV) begin
      errCount++;
      $display("[TB] FAIL %s: {j,k,busy,done,ready,err} got %b want %b", name, act, expV);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    checkCount++;
    if (got != want) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input string name, input logic rstN, input logic v, input logic [1:0] op,
                      input logic [CNT_W-1:0] len);
    applyStimulus(rstN, v, op, len);
    checkOutput(name, modelVec());
  endtask

  typedef struct {
    logic             rstN;
    logic             v;
    logic [1:0]       op;
    logic [CNT_W-1:0] len;
    logic [5:0]       expV;
  } vec_t;

  vec_t vecs[20];

  task automatic runVecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].v, vecs[i].op, vecs[i].len);
      checkOutput($sformatf("vec%0d", i), vecs[i].expV);
      checkOutput($sformatf("vec%0d_model", i), modelVec());
    end
  endtask

  initial begin
    // Reset with valid held, release, single set of len 2, then back-to-back reset/set/toggle.
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 4'd2, 6'b000000};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 4'd2, 6'b000000};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b000010};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b000010};
    vecs[4]  = '{1'b1, 1'b1, 2'b10, 4'd2, 6'b000010};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b101010};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b101010};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b101010};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b000110};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b000010};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 4'd0, 6'b000010};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 4'd1, 6'b011010};
    vecs[12] = '{1'b1, 1'b1, 2'b11, 4'd3, 6'b101110};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b101010};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b111110};
    vecs[15] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b111010};
    vecs[16] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b111010};
    vecs[17] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b111010};
    vecs[18] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b000110};
    vecs[19] = '{1'b1, 1'b0, 2'b00, 4'd0, 6'b000010};

    runVecs(0, 19);
    checkInt("ff_y_after_b2b", int'(ffY), 1);

    // Fill the FIFO behind a running command, offer a fifth, then drain.
    step("full_a", 1'b1, 1'b1, 2'b10, 4'd15);
    step("full_b", 1'b1, 1'b1, 2'b11, 4'd15);
    step("full_c", 1'b1, 1'b1, 2'b01, 4'd15);
    step("full_d", 1'b1, 1'b1, 2'b10, 4'd15);
    step("full_e", 1'b1, 1'b1, 2'b11, 4'd15);
    checkInt("full_ready_low", int'(cmd_ready), 0);
    step("full_drop", 1'b1, 1'b1, 2'b00, 4'd5);
    checkInt("drop_ready_low", int'(cmd_ready), 0);
    doneSeen = 0;
    for (int i = 0; i < 90; i++) begin
      step($sformatf("drain%0d", i), 1'b1, 1'b0, 2'b00, 4'd0);
      if (done) doneSeen++;
    end
    checkInt("drain_done_count", doneSeen, 5);
    checkInt("drain_idle", int'(busy), 0);

    // Reset during the third apply cycle of a len-7 toggle with another command queued.
    step("mid_push_tog", 1'b1, 1'b1, 2'b11, 4'd7);
    step("mid_push_set", 1'b1, 1'b1, 2'b10, 4'd3);
    step("mid_c2", 1'b1, 1'b0, 2'b00, 4'd0);
    step("mid_c3", 1'b1, 1'b0, 2'b00, 4'd0);
    checkOutput("mid_c3_tog", 6'b111010);
    step("mid_reset", 1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("mid_reset_out", 6'b000000);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("mid_rel%0d", i), 1'b1, 1'b0, 2'b00, 4'd0);
      checkOutput($sformatf("mid_rel%0d_quiet", i), 6'b000010);
    end

    for (int i = 0; i < 400; i++) begin
      step($sformatf("rand%0d", i), 1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 5)));
    end

`ifdef JK_CMD_SEQ_CHECK_EN
    step("chk_reset", 1'b0, 1'b0, 2'b00, 4'd0);
    runVecs(10, 19);
    checkInt("chk_err_clean", int'(err), 0);
    injectQ = 1'b1;
    step("chk_inject", 1'b1, 1'b0, 2'b00, 4'd0);
    injectQ = 1'b0;
    checkInt("chk_err_set", int'(err), 1);
    for (int i = 0; i < 3; i++) step($sformatf("chk_hold%0d", i), 1'b1, 1'b0, 2'b00, 4'd0);
    checkInt("chk_err_sticky", int'(err), 1);
    step("chk_clear", 1'b0, 1'b0, 2'b00, 4'd0);
    checkInt("chk_err_cleared", int'(err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
